// File: rtl/wb_arbiter.sv
// wb_arbiter: per-source hold slots drained round-robin into a registered RF write port.
// Define WB_FWD_EN to build the forwarding lookup logic; otherwise fwd_hit/fwd_data are 0.
module wb_arbiter #(
  parameter int N_SRC     = 3,
  parameter int FWD_PORTS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SRC-1:0]       src_valid,
  output logic [N_SRC-1:0]       src_ready,
  input  logic [N_SRC*5-1:0]     src_addr,
  input  logic [N_SRC*64-1:0]    src_data,
  output logic [4:0]             wa,
  output logic                   wvalid,
  output logic [63:0]            wd,
  input  logic [FWD_PORTS*5-1:0] fwd_ra,
  output logic [FWD_PORTS-1:0]   fwd_hit,
  output logic [FWD_PORTS*64-1:0] fwd_data,
  output logic                   idle
);
  localparam int RW = $clog2(N_SRC);
  localparam logic [RW-1:0] LAST = RW'(N_SRC - 1);

  logic [N_SRC-1:0] hold_v;
  logic [4:0]       hold_a [N_SRC];
  logic [63:0]      hold_d [N_SRC];
  logic [RW-1:0]    rr;
  logic [N_SRC-1:0] grant;
  logic [N_SRC-1:0] accept;
  logic [RW-1:0]    gidx;
  logic [RW-1:0]    scan;
  logic             found;

  // Rotating search from rr for the first occupied slot; depends on state only.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    scan  = rr;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && hold_v[scan]) begin
        found = 1'b1;
        gidx  = scan;
      end
      scan = (scan == LAST) ? '0 : scan + 1'b1;
    end
    if (found) grant[gidx] = 1'b1;
  end

  assign src_ready = ~hold_v | grant;
  assign idle      = ~|hold_v && !wvalid;

  // A handshake to x0 completes but never occupies a slot.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_SRC; i++) begin
      accept[i] = src_valid[i] && src_ready[i] &&
                  (src_addr[i*5 +: 5] != 5'd0);
    end
  end

  // Hold slots: reload wins over the drain of the granted slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        hold_a[i] <= '0;
        hold_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (accept[i]) begin
          hold_v[i] <= 1'b1;
          hold_a[i] <= src_addr[i*5 +: 5];
          hold_d[i] <= src_data[i*64 +: 64];
        end else if (grant[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
    end
  end

  // Registered write port and round-robin pointer advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      wvalid <= 1'b0;
      wa     <= '0;
      wd     <= '0;
      rr     <= '0;
    end else begin
      wvalid <= found;
      if (found) begin
        wa <= hold_a[gidx];
        wd <= hold_d[gidx];
        rr <= (gidx == LAST) ? '0 : gidx + 1'b1;
      end
    end
  end

`ifdef WB_FWD_EN
  // Lowest-index matching slot first, then the output register; x0 never hits.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int k = 0; k < FWD_PORTS; k++) begin
      if (fwd_ra[k*5 +: 5] != 5'd0) begin
        for (int i = 0; i < N_SRC; i++) begin
          if (!fwd_hit[k] && hold_v[i] &&
              hold_a[i] == fwd_ra[k*5 +: 5]) begin
            fwd_hit[k]            = 1'b1;
            fwd_data[k*64 +: 64]  = hold_d[i];
          end
        end
        if (!fwd_hit[k] && wvalid &&
            wa == fwd_ra[k*5 +: 5]) begin
          fwd_hit[k]           = 1'b1;
          fwd_data[k*64 +: 64] = wd;
        end
      end
    end
  end
`else
  logic unused_fwd_ra;
  assign unused_fwd_ra = ^fwd_ra;
  assign fwd_hit  = '0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed + random stimulus against a spec-level model,
// expected writes flow through a scoreboard queue checked by a negedge monitor.
module tb_wb_arbiter;
  localparam int N = 3;
  localparam int F = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N*5-1:0]  src_addr;
  logic [N*64-1:0] src_data;
  logic [4:0]      wa;
  logic            wvalid;
  logic [63:0]     wd;
  logic [F*5-1:0]  fwd_ra;
  logic [F-1:0]    fwd_hit;
  logic [F*64-1:0] fwd_data;
  logic            idle;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.N_SRC(N), .FWD_PORTS(F)) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data),
    .wa(wa), .wvalid(wvalid), .wd(wd),
    .fwd_ra(fwd_ra), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .idle(idle)
  );

  // Reference model state
  bit          mv [N];
  logic [4:0]  ma [N];
  logic [63:0] md [N];
  bit          macc [N];
  int          mrr;
  bit          mwv;
  logic [4:0]  mwa;
  logic [63:0] mwd;
  int          g;
  logic [68:0] exp_q [$];

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Slot closest (cyclically) at or after the pointer.
  function automatic int pick();
    int best;
    int bd;
    int d;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      if (mv[i]) begin
        d = (i - mrr + N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int gg;
    gg = pick();
    for (int i = 0; i < N; i++) r[i] = !mv[i] || (gg == i);
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mv[i] = 0; ma[i] = '0; md[i] = '0; macc[i] = 0;
      end
      mrr = 0; mwv = 0; mwa = '0; mwd = '0;
      exp_q.delete();
    end else begin
      g = pick();
      for (int i = 0; i < N; i++)
        macc[i] = src_valid[i] && (!mv[i] || g == i);
      if (g >= 0) begin
        exp_q.push_back({ma[g], md[g]});
        mwv = 1; mwa = ma[g]; mwd = md[g];
        mv[g] = 0;
        mrr = (g + 1) % N;
      end else begin
        mwv = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (macc[i] && src_addr[i*5 +: 5] != 5'd0) begin
          mv[i] = 1;
          ma[i] = src_addr[i*5 +: 5];
          md[i] = src_data[i*64 +: 64];
        end
      end
    end
  end

  // Monitor: compare visible outputs against model state each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [68:0] e;
      logic [4:0]  ra;
      bit          eh;
      logic [63:0] ed;
      bit          anyv;
      chk("src_ready", src_ready, exp_ready());
      chk("wvalid", wvalid, mwv);
      if (wvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL write_unexpected actual wa=%0h wd=%0h expected none", wa, wd);
        end else begin
          e = exp_q.pop_front();
          chk("write", {wa, wd}, e);
        end
      end else begin
        chk("wa_wd_hold", {wa, wd}, {mwa, mwd});
      end
      anyv = 0;
      for (int i = 0; i < N; i++) anyv |= mv[i];
      chk("idle", idle, !anyv && !mwv);
      for (int k = 0; k < F; k++) begin
        ra = fwd_ra[k*5 +: 5];
        eh = 0;
        ed = '0;
`ifdef WB_FWD_EN
        if (ra != 5'd0) begin
          for (int i = N - 1; i >= 0; i--) begin
            if (mv[i] && ma[i] == ra) begin
              eh = 1;
              ed = md[i];
            end
          end
          if (!eh && mwv && mwa == ra) begin
            eh = 1;
            ed = mwd;
          end
        end
`endif
        chk("fwd_hit", fwd_hit[k], eh);
        chk("fwd_data", fwd_data[k*64 +: 64], ed);
      end
    end
  end

  task automatic set_src(int i, bit v, logic [4:0] a, logic [63:0] d);
    src_valid[i]        = v;
    src_addr[i*5 +: 5]  = a;
    src_data[i*64 +: 64] = d;
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) set_src(i, 0, 5'd0, 64'd0);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset  = 1;
    fwd_ra = '0;
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
    step(1);
    mon_en = 1;
    step(1);
    reset = 0;
    @(negedge clk);
    chk("reset_idle", idle, 1'b1);
    chk("reset_wvalid", wvalid, 1'b0);
    chk("reset_ready", src_ready, 3'b111);

    // Single result: wvalid exactly two cycles after the handshake
    step(1);
    set_src(1, 1, 5'd5, 64'hAA);
    step(1);
    clear_src();
    @(negedge clk);
    chk("lat_t1_wvalid", wvalid, 1'b0);
    @(negedge clk);
    chk("lat_t2_wvalid", wvalid, 1'b1);
    chk("lat_t2_write", {wa, wd}, {5'd5, 64'hAA});
    @(negedge clk);
    chk("lat_t3_wvalid", wvalid, 1'b0);
    step(2);

    // Two simultaneous triples
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++)
        set_src(i, 1, 5'(i + 1), 64'(16 * r + i + 1));
      step(1);
      clear_src();
      step(5);
    end

    // Write to x0 is dropped
    set_src(0, 1, 5'd0, 64'h55);
    step(1);
    clear_src();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("x0_idle", idle, 1'b1);
      chk("x0_wvalid", wvalid, 1'b0);
    end
    step(1);

    // Back-to-back stream from source 2
    for (int c = 0; c < 4; c++) begin
      set_src(2, 1, 5'(8 + c), 64'(64'h100 + c));
      @(negedge clk);
      chk("stream_ready2", src_ready[2], 1'b1);
      step(1);
    end
    clear_src();
    step(5);

    // Same destination in slot and output register
    fwd_ra = {5'd7, 5'd7};
    set_src(0, 1, 5'd7, 64'h22);
    step(1);
    set_src(0, 1, 5'd7, 64'h11);
    step(1);
    clear_src();
    @(negedge clk);
`ifdef WB_FWD_EN
    chk("fwd_slot_hit", fwd_hit[0], 1'b1);
    chk("fwd_slot_data", fwd_data[63:0], 64'h11);
`else
    chk("fwd_off_hit", fwd_hit, 2'b00);
    chk("fwd_off_data", fwd_data, 128'd0);
`endif
    step(4);

    // Reset while slots are pending and a write is on the port
    for (int i = 0; i < N; i++) set_src(i, 1, 5'(9 + i), 64'(64'h900 + i));
    step(1);
    clear_src();
    step(1);
    reset = 1;
    step(1);
    reset = 0;
    @(negedge clk);
    chk("rst_mid_wvalid", wvalid, 1'b0);
    chk("rst_mid_idle", idle, 1'b1);
    chk("rst_mid_ready", src_ready, 3'b111);
    chk("rst_mid_wa", wa, 5'd0);
    step(3);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!src_valid[i] || macc[i]) begin
          if ($urandom_range(0, 3) != 0)
            set_src(i, 1, 5'($urandom_range(0, 7)),
                    {$urandom, $urandom});
          else
            set_src(i, 0, 5'd0, 64'd0);
        end
      end
      for (int k = 0; k < F; k++)
        fwd_ra[k*5 +: 5] = 5'($urandom_range(0, 7));
      reset = ($urandom_range(0, 299) == 0);
      step(1);
    end
    reset = 0;
    clear_src();
    step(8);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue actual=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
